// File: rtl/pwm_cfg_sched.sv
// pwm_cfg_sched: round-robin scheduler/configurator for the PWM datapath.
// NREQ requesters offer high/low count pairs. The first valid pair starts the
// PWM. While it runs, updates are applied only at a period boundary. The PWM
// stops when enable drops.
// Ports:
//   clk, reset      rising-edge clock, async active-low reset
//   enable          global run permission
//   req             per-requester update request (NREQ)
//   req_high/low    packed per-requester counts, slice i belongs to req[i]
//   period_end      datapath counter-reload pulse
//   grant, reject   one-hot acknowledge, invalid-config flag
//   cfg_high/low    counts to the datapath, cfg_load copy strobe
//   start, stop     control-unit pulses; running = START..STOP inclusive
//   owner           index of the last accepted requester
module pwm_cfg_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = 8,
  parameter int unsigned IW   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   req_high,
  input  logic [NREQ*CW-1:0]   req_low,
  input  logic                 period_end,
  output logic [NREQ-1:0]      grant,
  output logic                 reject,
  output logic [CW-1:0]        cfg_high,
  output logic [CW-1:0]        cfg_low,
  output logic                 cfg_load,
  output logic                 start,
  output logic                 stop,
  output logic                 running,
  output logic [IW-1:0]        owner
);

  typedef enum logic [3:0] {
    IDLE, REJI, LOAD, START, RUN, WAIT, APPLY, REJR, STOP
  } stateT;

  stateT           state, nextState;
  logic [IW-1:0]   rrPtr, nextPtr;
  logic [IW-1:0]   pend, nextPend;
  logic [IW-1:0]   winIdx, cand;
  logic            found;
  logic [CW-1:0]   winHigh, winLow, pendHigh, pendLow;

  logic [NREQ-1:0] nextGrant;
  logic            nextReject;
  logic [CW-1:0]   nextCfgHigh, nextCfgLow;
  logic            nextCfgLoad, nextStart, nextStop, nextRunning;
  logic [IW-1:0]   nextOwner;

  // (idx + step) modulo NREQ
  function automatic logic [IW-1:0] wrapInc(input logic [IW-1:0] idx,
                                            input int unsigned step);
    return IW'((32'(idx) + step) % NREQ);
  endfunction

  // Round-robin pick: first asserted req scanning upward from rrPtr
  always_comb begin
    winIdx = '0;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = wrapInc(rrPtr, k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winIdx = cand;
      end
    end
  end

  assign winHigh  = req_high[32'(winIdx) * CW +: CW];
  assign winLow   = req_low [32'(winIdx) * CW +: CW];
  assign pendHigh = req_high[32'(pend) * CW +: CW];
  assign pendLow  = req_low [32'(pend) * CW +: CW];

  // Next state plus next values of every registered output
  always_comb begin
    nextState   = state;
    nextPtr     = rrPtr;
    nextPend    = pend;
    nextGrant   = '0;
    nextReject  = 1'b0;
    nextCfgHigh = cfg_high;
    nextCfgLow  = cfg_low;
    nextOwner   = owner;

    unique case (state)
      IDLE: begin
        if (enable && found) begin
          nextGrant = NREQ'(1) << winIdx;
          nextPtr   = wrapInc(winIdx, 1);
          if (winHigh == '0 || winLow == '0) begin
            nextReject = 1'b1;
            nextState  = REJI;
          end else begin
            nextCfgHigh = winHigh;
            nextCfgLow  = winLow;
            nextOwner   = winIdx;
            nextState   = LOAD;
          end
        end
      end
      REJI:  nextState = IDLE;
      LOAD:  nextState = START;
      START: nextState = RUN;
      RUN: begin
        if (!enable) begin
          nextState = STOP;
        end else if (found) begin
          nextPend  = winIdx;
          nextState = WAIT;
        end
      end
      WAIT: begin
        // Stop outranks a coinciding period boundary; the request stays pending
        if (!enable) begin
          nextState = STOP;
        end else if (!req[pend]) begin
          nextState = RUN;
        end else if (period_end) begin
          nextGrant = NREQ'(1) << pend;
          nextPtr   = wrapInc(pend, 1);
          if (pendHigh == '0 || pendLow == '0) begin
            nextReject = 1'b1;
            nextState  = REJR;
          end else begin
            nextCfgHigh = pendHigh;
            nextCfgLow  = pendLow;
            nextOwner   = pend;
            nextState   = APPLY;
          end
        end
      end
      APPLY: nextState = RUN;
      REJR:  nextState = RUN;
      STOP:  nextState = IDLE;
      default: nextState = IDLE;
    endcase

    // Strobes decoded from the state being entered, so they are registered
    nextCfgLoad = (nextState == LOAD) || (nextState == APPLY);
    nextStart   = (nextState == START);
    nextStop    = (nextState == STOP);
    nextRunning = (nextState == START) || (nextState == RUN) ||
                  (nextState == WAIT)  || (nextState == APPLY) ||
                  (nextState == REJR)  || (nextState == STOP);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rrPtr    <= '0;
      pend     <= '0;
      grant    <= '0;
      reject   <= 1'b0;
      cfg_high <= '0;
      cfg_low  <= '0;
      cfg_load <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
      running  <= 1'b0;
      owner    <= '0;
    end else begin
      state    <= nextState;
      rrPtr    <= nextPtr;
      pend     <= nextPend;
      grant    <= nextGrant;
      reject   <= nextReject;
      cfg_high <= nextCfgHigh;
      cfg_low  <= nextCfgLow;
      cfg_load <= nextCfgLoad;
      start    <= nextStart;
      stop     <= nextStop;
      running  <= nextRunning;
      owner    <= nextOwner;
    end
  end

endmodule

// File: tb/tb_pwm_cfg_sched.sv
// Directed bench for pwm_cfg_sched with hand-computed expectations.
module tb_pwm_cfg_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned IW   = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [NREQ-1:0]      req;
  logic [NREQ*CW-1:0]   req_high;
  logic [NREQ*CW-1:0]   req_low;
  logic                 period_end;
  logic [NREQ-1:0]      grant;
  logic                 reject;
  logic [CW-1:0]        cfg_high;
  logic [CW-1:0]        cfg_low;
  logic                 cfg_load;
  logic                 start;
  logic                 stop;
  logic                 running;
  logic [IW-1:0]        owner;

  int errCnt = 0;
  int chkCnt = 0;

  pwm_cfg_sched #(.NREQ(NREQ), .CW(CW), .IW(IW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .req_high(req_high), .req_low(req_low), .period_end(period_end),
    .grant(grant), .reject(reject), .cfg_high(cfg_high), .cfg_low(cfg_low),
    .cfg_load(cfg_load), .start(start), .stop(stop), .running(running),
    .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setSlice(input int i, input logic [CW-1:0] hi, input logic [CW-1:0] lo);
    req_high[i*CW +: CW] = hi;
    req_low [i*CW +: CW] = lo;
  endtask

  // Called in RUN (or START) with req already set; ends in RUN with req=reqAfter
  task automatic updateRound(input string tag, input logic [3:0] reqAfter,
                             input logic [3:0] expGrant, input logic [7:0] expHigh,
                             input logic [7:0] expLow, input logic [1:0] expOwner);
    tick();                      // RUN -> WAIT
    repeat (3) tick();
    checkEq({tag, "_wait_grant"}, 32'(grant), 32'h0);
    checkEq({tag, "_wait_load"}, 32'(cfg_load), 32'h0);
    period_end = 1'b1;
    tick();                      // WAIT -> APPLY
    period_end = 1'b0;
    checkEq({tag, "_grant"}, 32'(grant), 32'(expGrant));
    checkEq({tag, "_load"}, 32'(cfg_load), 32'h1);
    checkEq({tag, "_high"}, 32'(cfg_high), 32'(expHigh));
    checkEq({tag, "_low"}, 32'(cfg_low), 32'(expLow));
    checkEq({tag, "_owner"}, 32'(owner), 32'(expOwner));
    checkEq({tag, "_running"}, 32'(running), 32'h1);
    req = reqAfter;
    tick();                      // APPLY -> RUN
    checkEq({tag, "_load_off"}, 32'(cfg_load), 32'h0);
    checkEq({tag, "_grant_off"}, 32'(grant), 32'h0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; req = '0; period_end = 1'b0;
    req_high = '0; req_low = '0;
    repeat (3) tick();

    // Reset state
    checkEq("rst_grant", 32'(grant), 32'h0);
    checkEq("rst_cfg_high", 32'(cfg_high), 32'h0);
    checkEq("rst_cfg_low", 32'(cfg_low), 32'h0);
    checkEq("rst_running", 32'(running), 32'h0);
    checkEq("rst_owner", 32'(owner), 32'h0);
    checkEq("rst_load", 32'(cfg_load), 32'h0);

    // Cold start: requester 0 with 3/5
    reset = 1'b1;
    enable = 1'b1;
    setSlice(0, 8'd3, 8'd5);
    req = 4'b0001;
    tick();                      // IDLE -> LOAD
    checkEq("cold_grant", 32'(grant), 32'h1);
    checkEq("cold_load", 32'(cfg_load), 32'h1);
    checkEq("cold_high", 32'(cfg_high), 32'd3);
    checkEq("cold_low", 32'(cfg_low), 32'd5);
    checkEq("cold_start_early", 32'(start), 32'h0);
    req = 4'b0000;
    tick();                      // LOAD -> START
    checkEq("cold_start", 32'(start), 32'h1);
    checkEq("cold_running", 32'(running), 32'h1);
    checkEq("cold_owner", 32'(owner), 32'h0);
    checkEq("cold_grant_off", 32'(grant), 32'h0);

    // Round robin (pointer is 1 after the cold-start grant)
    setSlice(0, 8'd9, 8'd1);
    setSlice(1, 8'd4, 8'd6);
    setSlice(3, 8'd7, 8'd2);
    req = 4'b1011;
    tick();                      // START -> RUN
    checkEq("run_start_off", 32'(start), 32'h0);
    updateRound("rr1", 4'b1001, 4'b0010, 8'd4, 8'd6, 2'd1);
    updateRound("rr2", 4'b0001, 4'b1000, 8'd7, 8'd2, 2'd3);
    updateRound("rr3", 4'b0000, 4'b0001, 8'd9, 8'd1, 2'd0);

    // Invalid config from requester 2
    setSlice(2, 8'd0, 8'd5);
    req = 4'b0100;
    tick();                      // RUN -> WAIT
    repeat (2) tick();
    period_end = 1'b1;
    tick();                      // WAIT -> REJR
    period_end = 1'b0;
    checkEq("inv_grant", 32'(grant), 32'h4);
    checkEq("inv_reject", 32'(reject), 32'h1);
    checkEq("inv_load", 32'(cfg_load), 32'h0);
    checkEq("inv_high", 32'(cfg_high), 32'd9);
    checkEq("inv_low", 32'(cfg_low), 32'd1);
    checkEq("inv_owner", 32'(owner), 32'd0);
    checkEq("inv_running", 32'(running), 32'h1);
    req = 4'b0000;
    tick();                      // REJR -> RUN
    checkEq("inv_reject_off", 32'(reject), 32'h0);

    // Withdrawal before the period boundary
    req = 4'b1000;
    tick();                      // RUN -> WAIT
    req = 4'b0000;
    tick();                      // WAIT -> RUN
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    checkEq("wd_grant", 32'(grant), 32'h0);
    checkEq("wd_load", 32'(cfg_load), 32'h0);
    tick();
    checkEq("wd_grant2", 32'(grant), 32'h0);
    checkEq("wd_load2", 32'(cfg_load), 32'h0);

    // Stop beats a coinciding period_end in WAIT
    req = 4'b1000;
    tick();                      // RUN -> WAIT
    enable = 1'b0;
    period_end = 1'b1;
    tick();                      // WAIT -> STOP
    period_end = 1'b0;
    checkEq("stop_pulse", 32'(stop), 32'h1);
    checkEq("stop_grant", 32'(grant), 32'h0);
    checkEq("stop_load", 32'(cfg_load), 32'h0);
    checkEq("stop_running", 32'(running), 32'h1);
    tick();                      // STOP -> IDLE
    checkEq("idle_stop_off", 32'(stop), 32'h0);
    checkEq("idle_running", 32'(running), 32'h0);
    checkEq("idle_cfg_high", 32'(cfg_high), 32'd9);
    checkEq("idle_cfg_low", 32'(cfg_low), 32'd1);
    tick();
    checkEq("idle_no_grant", 32'(grant), 32'h0);

    // Restart with pending requester 3 (pointer is 3)
    enable = 1'b1;
    tick();                      // IDLE -> LOAD
    checkEq("rs_grant", 32'(grant), 32'h8);
    checkEq("rs_high", 32'(cfg_high), 32'd7);
    checkEq("rs_owner", 32'(owner), 32'd3);
    req = 4'b0000;
    tick();                      // START
    tick();                      // RUN
    setSlice(1, 8'd5, 8'd5);
    req = 4'b0010;
    tick();                      // RUN -> WAIT
    period_end = 1'b1;
    tick();                      // WAIT -> APPLY
    period_end = 1'b0;
    checkEq("ap_load", 32'(cfg_load), 32'h1);
    checkEq("ap_grant", 32'(grant), 32'h2);

    // Async reset during APPLY
    #2;
    reset = 1'b0;
    #1;
    checkEq("ar_grant", 32'(grant), 32'h0);
    checkEq("ar_load", 32'(cfg_load), 32'h0);
    checkEq("ar_high", 32'(cfg_high), 32'h0);
    checkEq("ar_owner", 32'(owner), 32'h0);
    checkEq("ar_running", 32'(running), 32'h0);
    checkEq("ar_stop", 32'(stop), 32'h0);

    // After release the pointer is 0: req 0101 must pick requester 0
    req = 4'b0101;
    reset = 1'b1;
    tick();
    checkEq("ar_ptr_grant", 32'(grant), 32'h1);
    checkEq("ar_ptr_reject", 32'(reject), 32'h0);
    req = 4'b0000;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
